dsp_slice_param: RTL
====================

DSP_SLICE_PARAM -- requirements
Module: dsp_slice_param

Interface
REQ-001 A_W, 18, width of the A, B, D and BCOUT paths.
REQ-002 P_W, 48, width of the C, PCIN, P and PCOUT paths; P_W SHALL be at least 2*A_W.
REQ-003 IREG / MREG / PREG, 1 / 1 / 1, each 0 or 1; enables the input stage, multiplier stage and output stage register respectively.
REQ-004 SAT_EN, 0; when 1, the post-adder result saturates instead of wrapping.
REQ-005 PATTERN, 0; P_W-bit constant compared against P.
REQ-006 CLK  in  1  single clock; all registers update on the rising edge.
REQ-007 RST  in  1  asynchronous, active-high reset for every register.
REQ-008 CE  in  1  global clock enable; when low, every register holds its value.
REQ-009 A, B, D  in  A_W each  unsigned operands.
REQ-010 C, PCIN  in  P_W each  post-adder operands.
REQ-011 CARRYIN  in  1  unused when OPMODE[5] is the carry source (see REQ-018); reserved.
REQ-012 OPMODE  in  8  operation control word.
REQ-013 IN_VALID  in  1  qualifies the operand set on the current cycle.
REQ-014 P, PCOUT  out  P_W each  result; PCOUT SHALL equal P at all times.
REQ-015 M  out  2*A_W  multiplier result.
REQ-016 BCOUT  out  A_W  pre-adder output.
REQ-017 Single-bit outputs: CARRYOUT, OVERFLOW, PATTERNDETECT, OUT_VALID.

Function
REQ-018 OPMODE decode:
- [1:0] selects X: 0 = zero, 1 = M zero-extended, 2 = P, 3 = {D[P_W-2*A_W-1:0], A, B}.
- [3:2] selects Z: 0 = zero, 1 = PCIN, 2 = P, 3 = C.
- [4] enables the pre-adder.
- [5] is the carry-in bit (CIN).
- [6] selects pre-adder subtract.
- [7] selects post-adder subtract.
REQ-019 Pre-adder output: BCOUT = B when OPMODE[4]=0; D+B when OPMODE[4]=1 and OPMODE[6]=0; D-B when OPMODE[4]=1 and OPMODE[6]=1; all modulo 2^A_W.
REQ-020 M = BCOUT * A, unsigned, full 2*A_W-bit width.
REQ-021 Post-adder: R = Z + (X + CIN) when OPMODE[7]=0, R = Z - (X + CIN) when OPMODE[7]=1; computed at P_W+1 bits.
REQ-022 CARRYOUT = R[P_W], registered together with P.
REQ-023 With SAT_EN=0, P = R[P_W-1:0] and OVERFLOW = 0.
REQ-024 With SAT_EN=1 and CARRYOUT=1: on add, P = all ones; on subtract, P = 0; in both cases OVERFLOW = 1 for that result.
REQ-025 PATTERNDETECT = (P == PATTERN); it SHALL be updated in the same cycle as P.
REQ-026 Latency from operands to P is IREG+MREG+PREG cycles (3 by default). M appears after IREG+MREG cycles; BCOUT appears after IREG cycles.
REQ-027 OPMODE and CARRYIN are captured in the input stage and SHALL travel with their data through the M stage, so control always matches its operands.
REQ-028 OUT_VALID is IN_VALID delayed by the same IREG+MREG+PREG register shift chain, gated by CE.
REQ-029 X=2 or Z=2 (P feedback) with PREG=0 SHALL treat the P operand as zero.
REQ-030 An IN_VALID=0 cycle still advances the pipeline; OUT_VALID=0 marks that result as don't-care.
REQ-031 When CE is low, all stages and OUT_VALID hold; accumulation pauses without losing state.

Reset
REQ-032 While RST=1, every register SHALL clear immediately, independent of CLK and CE: P, PCOUT, M, BCOUT, CARRYOUT, OVERFLOW and OUT_VALID go to 0.
REQ-033 PATTERNDETECT during reset SHALL equal (PATTERN == 0).
REQ-034 A reset mid-accumulation discards all in-flight results; the first valid output after RST falls is the first operand set captured after release.

Structure
REQ-035 The OPMODE field positions and the X/Z selector encodings SHALL be localparams in the shared dsp_pkg.
REQ-036 One sub-module, dsp_pipe_reg, SHALL implement a parameter-width register with async reset, CE and a bypass parameter; it is instantiated for every optional stage.

Verification
REQ-037 Reset: RST=1 with A=B=D=1, C=1, PCIN=1 -> all outputs 0 before any clock edge; OUT_VALID=0.
REQ-038 Multiply: default parameters, OPMODE=0x01, A=5, B=3, IN_VALID pulsed once -> M=15 on edge 2, P=15 and PCOUT=15 on edge 3, OUT_VALID high exactly on edge 3.
REQ-039 Full path: OPMODE=0xF5, A=10, B=10, D=20, PCIN=200 -> BCOUT=10, M=100, P=99, CARRYOUT=0.
REQ-040 Accumulate: OPMODE=0x09 (Z=P, X=M), A=2, B=3, held 4 cycles after P=0 -> P steps 6, 12, 18, 24; deasserting CE for 2 cycles holds P at its current value.
REQ-041 Saturation:
- SAT_EN=1, C=2^48-1, OPMODE=0x0D, A=1, B=1 -> P=2^48-1, CARRYOUT=1, OVERFLOW=1.
- OPMODE=0x81, A=5, B=1 -> P=0, OVERFLOW=1.
REQ-042 Bypass: IREG=MREG=PREG=0, OPMODE=0x01, A=7, B=6 -> P=42 in the same cycle; PATTERN=42 -> PATTERNDETECT=1.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared OPMODE field positions and X/Z operand selector encodings for the DSP slice.
package dsp_pkg;
   localparam int OP_X_LSB    = 0;
   localparam int OP_X_MSB    = 1;
   localparam int OP_Z_LSB    = 2;
   localparam int OP_Z_MSB    = 3;
   localparam int OP_PRE_EN   = 4;
   localparam int OP_CIN      = 5;
   localparam int OP_PRE_SUB  = 6;
   localparam int OP_POST_SUB = 7;

   localparam logic [1:0] X_ZERO = 2'd0;
   localparam logic [1:0] X_M    = 2'd1;
   localparam logic [1:0] X_P    = 2'd2;
   localparam logic [1:0] X_DAB  = 2'd3;

   localparam logic [1:0] Z_ZERO = 2'd0;
   localparam logic [1:0] Z_PCIN = 2'd1;
   localparam logic [1:0] Z_P    = 2'd2;
   localparam logic [1:0] Z_C    = 2'd3;
endpackage

// File: rtl/dsp_pipe_reg.sv
// Optional pipeline register: async reset, clock enable, and a pass-through when EN is 0.
module dsp_pipe_reg #(
   parameter int W  = 1,
   parameter int EN = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] q_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     q_r <= '0;
      else if (ce) q_r <= d;
   end

   assign q = (EN != 0) ? q_r : d;
endmodule

// File: rtl/dsp_slice_param.sv
// Parameterised DSP slice: pre-adder, unsigned multiplier, post-adder with
// optional saturation, pattern detect and a valid flag riding the pipeline.
module dsp_slice_param
   import dsp_pkg::*;
#(
   parameter int             A_W     = 18,
   parameter int             P_W     = 48,
   parameter int             IREG    = 1,
   parameter int             MREG    = 1,
   parameter int             PREG    = 1,
   parameter int             SAT_EN  = 0,
   parameter logic [P_W-1:0] PATTERN = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CE,
   input  logic [A_W-1:0]   A,
   input  logic [A_W-1:0]   B,
   input  logic [A_W-1:0]   D,
   input  logic [P_W-1:0]   C,
   input  logic [P_W-1:0]   PCIN,
   input  logic             CARRYIN,
   input  logic [7:0]       OPMODE,
   input  logic             IN_VALID,
   output logic [P_W-1:0]   P,
   output logic [P_W-1:0]   PCOUT,
   output logic [2*A_W-1:0] M,
   output logic [A_W-1:0]   BCOUT,
   output logic             CARRYOUT,
   output logic             OVERFLOW,
   output logic             PATTERNDETECT,
   output logic             OUT_VALID
);
   localparam int S1_W = 8 + 1 + 1 + 3*A_W + 2*P_W;
   localparam int S2_W = S1_W + 2*A_W;
   localparam int S3_W = P_W + 3;

   logic [7:0]       op_p1, op_p2;
   logic             cin_p1, cin_p2, vld_p1, vld_p2;
   logic [A_W-1:0]   a_p1, b_p1, d_p1, a_p2, b_p2, d_p2;
   logic [P_W-1:0]   c_p1, pcin_p1, c_p2, pcin_p2;
   logic [2*A_W-1:0] m_p1, m_p2;
   logic [3*A_W-1:0] dab_p2;
   logic [P_W-1:0]   p_fb, x_p2, z_p2, pn_p2;
   logic [P_W:0]     xc_p2, r_p2;
   logic             ovf_p2;
   logic             unused_ctrl;

   function automatic logic [A_W-1:0] pre_add(input logic [7:0] op,
                                              input logic [A_W-1:0] d, input logic [A_W-1:0] b);
      if (!op[OP_PRE_EN])   return b;
      if (op[OP_PRE_SUB])   return d - b;
      return d + b;
   endfunction

   // Result layout is {overflow, p}; saturation only triggers on carry/borrow out.
   function automatic logic [P_W:0] saturate(input logic [P_W:0] r, input logic sub);
      logic [P_W-1:0] lim;
      lim = sub ? '0 : '1;
      if (SAT_EN != 0 && r[P_W]) return {1'b1, lim};
      return {1'b0, r[P_W-1:0]};
   endfunction

   // Stage 1: operands and control captured together
   dsp_pipe_reg #(.W(S1_W), .EN(IREG)) u_in_reg (
      .clk(CLK), .rst(RST), .ce(CE),
      .d({OPMODE, CARRYIN, IN_VALID, D, A, B, C, PCIN}),
      .q({op_p1, cin_p1, vld_p1, d_p1, a_p1, b_p1, c_p1, pcin_p1})
   );

   assign BCOUT = pre_add(op_p1, d_p1, b_p1);
   assign m_p1  = (2*A_W)'(BCOUT) * (2*A_W)'(a_p1);

   // Stage 2: product plus the control/operands it belongs to
   dsp_pipe_reg #(.W(S2_W), .EN(MREG)) u_m_reg (
      .clk(CLK), .rst(RST), .ce(CE),
      .d({op_p1, cin_p1, vld_p1, d_p1, a_p1, b_p1, c_p1, pcin_p1, m_p1}),
      .q({op_p2, cin_p2, vld_p2, d_p2, a_p2, b_p2, c_p2, pcin_p2, m_p2})
   );

   assign M      = m_p2;
   assign dab_p2 = {d_p2, a_p2, b_p2};
   assign p_fb   = (PREG != 0) ? P : '0;

   always_comb begin
      x_p2 = '0;
      case (op_p2[OP_X_MSB:OP_X_LSB])
         X_ZERO:  x_p2 = '0;
         X_M:     x_p2 = P_W'(m_p2);
         X_P:     x_p2 = p_fb;
         X_DAB:   x_p2 = P_W'(dab_p2);
         default: x_p2 = '0;
      endcase
      z_p2 = '0;
      case (op_p2[OP_Z_MSB:OP_Z_LSB])
         Z_ZERO:  z_p2 = '0;
         Z_PCIN:  z_p2 = pcin_p2;
         Z_P:     z_p2 = p_fb;
         Z_C:     z_p2 = c_p2;
         default: z_p2 = '0;
      endcase
      xc_p2 = {1'b0, x_p2} + {{P_W{1'b0}}, op_p2[OP_CIN]};
      r_p2  = op_p2[OP_POST_SUB] ? ({1'b0, z_p2} - xc_p2) : ({1'b0, z_p2} + xc_p2);
      {ovf_p2, pn_p2} = saturate(r_p2, op_p2[OP_POST_SUB]);
   end

   // Stage 3: result, flags and valid
   dsp_pipe_reg #(.W(S3_W), .EN(PREG)) u_p_reg (
      .clk(CLK), .rst(RST), .ce(CE),
      .d({vld_p2, r_p2[P_W], ovf_p2, pn_p2}),
      .q({OUT_VALID, CARRYOUT, OVERFLOW, P})
   );

   assign PCOUT         = P;
   assign PATTERNDETECT = (P == PATTERN);

   // CARRYIN is reserved; pre-adder controls are consumed before the M stage.
   assign unused_ctrl = ^{cin_p2, op_p2[OP_PRE_EN], op_p2[OP_PRE_SUB]};
endmodule
